puf_resp_reader: RTL and testbench

- System-clock-side consumer of the PUF ring-oscillator counter interface (enable out; valid/count in).
- Per response bit, measures an RO pair (A = even index, B = odd index) via an external RO select, and compares the two counts.
- Assembles a RESP_BITS-wide response word.
- Handles the clock-domain crossing from the RO-clocked valid/count, plus timeouts, ties and abort.

---
 rtl/puf_resp_reader.sv | 244 ++++++++++++++++++++++++
 tb/tb_puf_resp_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_resp_reader.sv
// puf_resp_reader: system-clock-side reader for a ring-oscillator PUF counter.
// For every response bit it measures RO A (even select) and then RO B (odd select).
// It compares the two counts and assembles a RESP_BITS-wide response word.
// The RO-clocked valid is synchronised before use. Every wait phase is guarded
// by a timeout that aborts the run.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   i_start           run request, honoured only when idle
//   i_valid, i_count  PUF measurement valid (asynchronous) and count
//   o_en              PUF enable; low clears the PUF counter and its valid
//   o_sel             RO select = 2*bit_idx + phase (phase 0 = A, 1 = B)
//   o_resp            response word, bit i = result of pair i
//   o_busy, o_done    run in progress / one-cycle end-of-run pulse
//   o_err, o_tie      timeout abort flag / some pair compared equal this run
//
// Optional build macro PUF_RESP_MAJ_EN: each pair is measured three times.
// The response bit is then the majority of the three A>B votes.
module puf_resp_reader #(
    parameter int unsigned CNT_BIT_SIZE = 5,
    parameter int unsigned RESP_BITS    = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned TIMEOUT_CYC  = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_start,
    input  logic                           i_valid,
    input  logic [CNT_BIT_SIZE-1:0]        i_count,
    output logic                           o_en,
    output logic [$clog2(2*RESP_BITS)-1:0] o_sel,
    output logic [RESP_BITS-1:0]           o_resp,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_err,
    output logic                           o_tie
);
    localparam int unsigned SelW = $clog2(2 * RESP_BITS);
    localparam int unsigned IdxW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(RESP_BITS - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StArm, StWaitV, StCap, StWaitClr, StNext, StDone, StAbort
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [IdxW-1:0]         bit_idx_q, bit_idx_d;
    logic                    phase_q, phase_d;
    logic [TmoW-1:0]         tmo_q, tmo_d;
    logic [CNT_BIT_SIZE-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_BIT_SIZE-1:0] cnt_b_q, cnt_b_d;
    logic                    en_q, en_d;
    logic [SelW-1:0]         sel_q, sel_d;
    logic [RESP_BITS-1:0]    resp_q, resp_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    tie_q, tie_d;
    logic                    v_s, vote, tie_now, tmo_hit, go_abort, pair_done;
`ifdef PUF_RESP_MAJ_EN
    logic [1:0]              trial_q, trial_d;
    logic [1:0]              votes_q, votes_d, votes_sum;
`endif

    // Oldest stage is the MSB; only the synchronised copy v_s is ever used.
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], i_valid};
    assign v_s     = sync_q[SYNC_STAGES-1];
    assign vote    = cnt_a_q > cnt_b_q;
    assign tie_now = cnt_a_q == cnt_b_q;
    assign tmo_hit = tmo_q >= TmoLast;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        phase_d   = phase_q;
        tmo_d     = tmo_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        en_d      = en_q;
        sel_d     = sel_q;
        resp_d    = resp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        tie_d     = tie_q;
        go_abort  = 1'b0;
        pair_done = 1'b1;
`ifdef PUF_RESP_MAJ_EN
        trial_d   = trial_q;
        votes_d   = votes_q;
        votes_sum = votes_q + {1'b0, vote};
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    bit_idx_d = '0;
                    phase_d   = 1'b0;
                    sel_d     = '0;
                    err_d     = 1'b0;
                    tie_d     = 1'b0;
                    resp_d    = '0;
                    busy_d    = 1'b1;
`ifdef PUF_RESP_MAJ_EN
                    trial_d   = '0;
                    votes_d   = '0;
`endif
                    state_d   = StArm;
                end
            end
            StArm: begin
                // o_sel was settled on entry here, so it is stable before o_en rises.
                en_d    = 1'b1;
                tmo_d   = '0;
                state_d = StWaitV;
            end
            StWaitV: begin
                if (v_s) begin
                    state_d = StCap;
                end else if (tmo_hit) begin
                    go_abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StCap: begin
                // Count is held stable by the PUF for as long as valid is high.
                if (phase_q) cnt_b_d = i_count;
                else         cnt_a_d = i_count;
                en_d    = 1'b0;
                tmo_d   = '0;
                state_d = StWaitClr;
            end
            StWaitClr: begin
                if (!v_s) begin
                    state_d = StNext;
                end else if (tmo_hit) begin
                    go_abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StNext: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sel_d   = SelW'({bit_idx_q, 1'b1});
                    state_d = StArm;
                end else begin
                    if (tie_now) tie_d = 1'b1;
                    phase_d = 1'b0;
`ifdef PUF_RESP_MAJ_EN
                    if (trial_q == 2'd2) begin
                        resp_d[bit_idx_q] = votes_sum[1];
                        trial_d = '0;
                        votes_d = '0;
                    end else begin
                        pair_done = 1'b0;
                        trial_d   = trial_q + 2'd1;
                        votes_d   = votes_sum;
                    end
`else
                    resp_d[bit_idx_q] = vote;
`endif
                    if (!pair_done) begin
                        sel_d   = SelW'({bit_idx_q, 1'b0});
                        state_d = StArm;
                    end else if (bit_idx_q == IdxLast) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        sel_d     = SelW'({bit_idx_d, 1'b0});
                        state_d   = StArm;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort keeps the bits already completed in resp.
        if (go_abort) begin
            en_d    = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StAbort;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sync_q    <= '0;
            bit_idx_q <= '0;
            phase_q   <= 1'b0;
            tmo_q     <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            en_q      <= 1'b0;
            sel_q     <= '0;
            resp_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tie_q     <= 1'b0;
`ifdef PUF_RESP_MAJ_EN
            trial_q   <= '0;
            votes_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            bit_idx_q <= bit_idx_d;
            phase_q   <= phase_d;
            tmo_q     <= tmo_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            en_q      <= en_d;
            sel_q     <= sel_d;
            resp_q    <= resp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tie_q     <= tie_d;
`ifdef PUF_RESP_MAJ_EN
            trial_q   <= trial_d;
            votes_q   <= votes_d;
`endif
        end
    end

    assign o_en   = en_q;
    assign o_sel  = sel_q;
    assign o_resp = resp_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_err  = err_q;
    assign o_tie  = tie_q;

endmodule

// File: tb/tb_puf_resp_reader.sv
// Directed bench for puf_resp_reader with a behavioural PUF model.
// The model raises valid a fixed number of cycles after o_en rises, off the clock
// edge, and can be told to hang or to hold valid high. Expected RO selects go into
// a scoreboard queue and are popped on every o_en rise.
module tb_puf_resp_reader;
    localparam int unsigned CntW       = 5;
    localparam int unsigned RespBits   = 8;
    localparam int unsigned SyncStages = 2;
    localparam int unsigned TimeoutCyc = 1024;
    localparam int unsigned SelW       = $clog2(2 * RespBits);
    localparam int          PufDelay   = 40;
`ifdef PUF_RESP_MAJ_EN
    localparam int          Trials     = 3;
`else
    localparam int          Trials     = 1;
`endif
    localparam int RunBudget = Trials * RespBits * 2 * (PufDelay + 20) + 200;

    logic                clk, rst_n, i_start, i_valid;
    logic [CntW-1:0]     i_count;
    logic                o_en, o_busy, o_done, o_err, o_tie;
    logic [SelW-1:0]     o_sel;
    logic [RespBits-1:0] o_resp;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int rise_cyc = 0;
    int a_tab [RespBits];
    int b_tab [RespBits];
    int a_q [$];
    int b_q [$];
    int sel_exp [$];
    bit hang_en     = 1'b0;
    bit stuck_valid = 1'b0;
    int hang_sel    = 0;

    puf_resp_reader #(
        .CNT_BIT_SIZE(CntW),
        .RESP_BITS   (RespBits),
        .SYNC_STAGES (SyncStages),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(i_start),
        .i_valid(i_valid),
        .i_count(i_count),
        .o_en   (o_en),
        .o_sel  (o_sel),
        .o_resp (o_resp),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_err  (o_err),
        .o_tie  (o_tie)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [RespBits-1:0] exp_resp();
        logic [RespBits-1:0] r;
        r = '0;
        for (int i = 0; i < RespBits; i++) r[i] = (a_tab[i] > b_tab[i]);
        return r;
    endfunction

    function automatic logic exp_tie();
        logic t;
        t = 1'b0;
        for (int i = 0; i < RespBits; i++) if (a_tab[i] == b_tab[i]) t = 1'b1;
        return t;
    endfunction

    // Expected select sequence: full pairs (all trials), then a partial tail.
    task automatic push_sels(input int full_pairs, input int tail);
        for (int p = 0; p < full_pairs; p++)
            for (int t = 0; t < Trials; t++) begin
                sel_exp.push_back(2 * p);
                sel_exp.push_back(2 * p + 1);
            end
        for (int s = 0; s < tail; s++) sel_exp.push_back(2 * full_pairs + s);
    endtask

    // PUF model: valid rises PufDelay cycles into the enable window, 3 ns past the edge.
    initial begin
        int en_cnt;
        int pair;
        i_valid = 1'b0;
        i_count = '0;
        en_cnt  = 0;
        forever begin
            @(posedge clk);
            #3;
            if (!rst_n) begin
                i_valid = ~i_valid;
                en_cnt  = 0;
            end else if (!o_en) begin
                if (!stuck_valid) i_valid = 1'b0;
                en_cnt = 0;
            end else begin
                en_cnt++;
                if (en_cnt == PufDelay && !(hang_en && int'(o_sel) == hang_sel)) begin
                    pair = int'(o_sel >> 1);
                    if (o_sel[0]) begin
                        if (b_q.size() > 0) i_count = CntW'(b_q.pop_front());
                        else                i_count = CntW'(b_tab[pair]);
                    end else begin
                        if (a_q.size() > 0) i_count = CntW'(a_q.pop_front());
                        else                i_count = CntW'(a_tab[pair]);
                    end
                    i_valid = 1'b1;
                end
            end
        end
    end

    // Monitor: select order on each enable, select stability while enabled, done pulses.
    initial begin
        logic            en_prev;
        logic [SelW-1:0] sel_prev;
        en_prev  = 1'b0;
        sel_prev = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_en && !en_prev) begin
                    rise_cyc = cyc;
                    check("sel_avail", 32'(sel_exp.size() > 0), 32'd1);
                    if (sel_exp.size() > 0) check("sel_order", 32'(o_sel), 32'(sel_exp.pop_front()));
                end else if (o_en) begin
                    check("sel_stable", 32'(o_sel), 32'(sel_prev));
                end
                if (o_done) done_cnt++;
            end
            en_prev  = o_en;
            sel_prev = o_sel;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Full run, with stray starts mid-run and in the done cycle that must be ignored.
    task automatic run_and_check(input string tag, input logic [RespBits-1:0] r_exp,
                                 input logic t_exp);
        bit ok;
        int d0;
        d0 = done_cnt;
        pulse_start();
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        check({tag, "_err_clr"}, 32'(o_err), 32'd0);
        repeat (100) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(RunBudget, ok);
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        check({tag, "_resp"}, 32'(o_resp), 32'(r_exp));
        check({tag, "_tie"}, 32'(o_tie), 32'(t_exp));
        check({tag, "_err"}, 32'(o_err), 32'd0);
        check({tag, "_busy_off"}, 32'(o_busy), 32'd0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_idle"}, 32'({o_busy, o_en}), 32'd0);
        check({tag, "_sel_left"}, 32'(sel_exp.size()), 32'd0);
    endtask

    initial begin
        bit ok;
        int d0;
        logic [RespBits-1:0] r;
        rst_n   = 1'b0;
        i_start = 1'b0;

        // Reset held while start and valid toggle.
        repeat (3) begin
            @(negedge clk);
            i_start = ~i_start;
            check("rst_ctrl", 32'({o_en, o_busy, o_done, o_err, o_tie}), 32'd0);
            check("rst_sel", 32'(o_sel), 32'd0);
            check("rst_resp", 32'(o_resp), 32'd0);
        end
        i_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_idle", 32'({o_en, o_busy, o_done}), 32'd0);

        // Nominal run with one tie.
        a_tab = '{20, 3, 9, 9, 31, 0, 15, 16};
        b_tab = '{10, 4, 2, 9, 30, 1, 14, 17};
        push_sels(RespBits, 0);
        run_and_check("run1", exp_resp(), exp_tie());

        // Valid never arrives for pair 2, phase B.
        hang_en  = 1'b1;
        hang_sel = 5;
        push_sels(2, 2);
        d0 = done_cnt;
        pulse_start();
        wait_done(RunBudget + TimeoutCyc, ok);
        check("hang_done_seen", 32'(ok), 32'd1);
        check("hang_err", 32'(o_err), 32'd1);
        check("hang_resp", 32'(o_resp), 32'(exp_resp() & RespBits'(3)));
        check("hang_en", 32'(o_en), 32'd0);
        check("hang_tie", 32'(o_tie), 32'd0);
        check("hang_latency", 32'((cyc - rise_cyc) >= int'(TimeoutCyc) &&
                                  (cyc - rise_cyc) <= int'(TimeoutCyc) + 2), 32'd1);
        hang_en = 1'b0;
        repeat (3) @(negedge clk);
        check("hang_one_done", 32'(done_cnt - d0), 32'd1);
        check("hang_sel_left", 32'(sel_exp.size()), 32'd0);

        // Valid held high after enable drops.
        stuck_valid = 1'b1;
        push_sels(0, 1);
        pulse_start();
        wait_done(PufDelay + TimeoutCyc + 100, ok);
        check("stuck_done_seen", 32'(ok), 32'd1);
        check("stuck_err", 32'(o_err), 32'd1);
        check("stuck_resp", 32'(o_resp), 32'd0);
        check("stuck_en_busy", 32'({o_en, o_busy}), 32'd0);
        stuck_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Recovery run, including all-ones counts.
        a_tab = '{31, 0, 31, 5, 17, 31, 1, 30};
        b_tab = '{0, 31, 31, 4, 18, 30, 1, 31};
        push_sels(RespBits, 0);
        run_and_check("run2", exp_resp(), exp_tie());

        // Reset asserted while waiting for valid.
        push_sels(0, 1);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (o_en) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_en_seen", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_en", 32'(o_en), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_resp", 32'(o_resp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_sel_left", 32'(sel_exp.size()), 32'd0);
        repeat (6) @(negedge clk);

`ifdef PUF_RESP_MAJ_EN
        // Pair 0 votes 1,0,1 -> bit 1, no tie anywhere.
        a_tab = '{20, 3, 9, 8, 31, 0, 15, 16};
        b_tab = '{10, 4, 2, 9, 30, 1, 14, 17};
        a_q = '{20, 5, 20};
        b_q = '{10, 9, 10};
        r = exp_resp();
        r[0] = 1'b1;
        push_sels(RespBits, 0);
        run_and_check("maj1", r, 1'b0);
        // Pair 0 votes 0,0(tie),1 -> bit 0 with tie.
        a_q = '{3, 9, 20};
        b_q = '{8, 9, 10};
        r = exp_resp();
        r[0] = 1'b0;
        push_sels(RespBits, 0);
        run_and_check("maj2", r, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
